// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: ring buffer of committed-instruction records with PC trigger,
// pre/post-trigger window and valid/ready readout. Optional HI/LO capture via TRACE_HILO_EN.
module commit_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int RA_W   = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   arm,
  input  logic [DATA_W-1:0]      trig_pc,
  input  logic [$clog2(DEPTH):0] post_cnt,
  input  logic                   commit_valid,
  input  logic [DATA_W-1:0]      commit_pc,
  input  logic [DATA_W-1:0]      commit_inst,
  input  logic [DATA_W-1:0]      commit_wdata,
  input  logic                   commit_wen,
  input  logic [RA_W-1:0]        commit_waddr,
`ifdef TRACE_HILO_EN
  input  logic [DATA_W-1:0]      commit_hi,
  input  logic [DATA_W-1:0]      commit_lo,
  output logic [DATA_W-1:0]      rd_hi,
  output logic [DATA_W-1:0]      rd_lo,
`endif
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_pc,
  output logic [DATA_W-1:0]      rd_inst,
  output logic [DATA_W-1:0]      rd_wdata,
  output logic                   rd_wen,
  output logic [RA_W-1:0]        rd_waddr,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  // state | meaning
  // IDLE  | no capture, no readout
  // ARMED | recording every commit, watching for trig_pc
  // POST  | trigger seen, recording remaining post-trigger commits
  // DONE  | buffer frozen, streaming oldest-first until empty

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_POST  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          cur_state;
  state_t          next_state;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   remaining;
  logic [CW-1:0]   post_lat;
  logic [CW-1:0]   post_clamped;
  logic            ovf;
  logic            wr_en;
  logic            rd_pop;
  logic            trig_hit;
  logic            head_valid;

  logic [DATA_W-1:0] mem_pc    [DEPTH];
  logic [DATA_W-1:0] mem_inst  [DEPTH];
  logic [DATA_W-1:0] mem_wdata [DEPTH];
  logic              mem_wen   [DEPTH];
  logic [RA_W-1:0]   mem_waddr [DEPTH];
`ifdef TRACE_HILO_EN
  logic [DATA_W-1:0] mem_hi    [DEPTH];
  logic [DATA_W-1:0] mem_lo    [DEPTH];
`endif

  assign post_clamped = (post_cnt > MAX_POST) ? MAX_POST : post_cnt;

  // The oldest record sits count entries behind the write pointer; when full
  // this wraps to wr_ptr itself, which is exactly the oldest surviving slot.
  assign rd_ptr     = wr_ptr - cnt[PW-1:0];
  assign head_valid = (cur_state == S_DONE) && (cnt != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    wr_en      = 1'b0;
    rd_pop     = 1'b0;
    trig_hit   = 1'b0;
    if (arm) begin
      next_state = S_ARMED;
    end else begin
      case (cur_state)
        S_ARMED: begin
          if (commit_valid) begin
            wr_en = 1'b1;
            if (commit_pc == trig_pc) begin
              trig_hit   = 1'b1;
              next_state = (post_lat == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (commit_valid) begin
            wr_en = 1'b1;
            if (remaining == CW'(1)) begin
              next_state = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (head_valid && rd_ready) begin
            rd_pop = 1'b1;
            if (cnt == CW'(1)) begin
              next_state = S_IDLE;
            end
          end else if (cnt == '0) begin
            next_state = S_IDLE;
          end
        end
        default: begin
          next_state = cur_state;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
      post_lat  <= '0;
    end else if (arm) begin
      wr_ptr    <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
      post_lat  <= post_clamped;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (cnt == FULL) begin
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (trig_hit) begin
        remaining <= post_lat;
      end else if (wr_en && (cur_state == S_POST)) begin
        remaining <= remaining - 1'b1;
      end
      if (rd_pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Record storage carries no reset; contents are only observable in DONE.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_pc[wr_ptr]    <= commit_pc;
      mem_inst[wr_ptr]  <= commit_inst;
      mem_wdata[wr_ptr] <= commit_wdata;
      mem_wen[wr_ptr]   <= commit_wen;
      mem_waddr[wr_ptr] <= commit_waddr;
`ifdef TRACE_HILO_EN
      mem_hi[wr_ptr]    <= commit_hi;
      mem_lo[wr_ptr]    <= commit_lo;
`endif
    end
  end

  assign rd_valid = head_valid;
  assign rd_pc    = head_valid ? mem_pc[rd_ptr]    : '0;
  assign rd_inst  = head_valid ? mem_inst[rd_ptr]  : '0;
  assign rd_wdata = head_valid ? mem_wdata[rd_ptr] : '0;
  assign rd_wen   = head_valid ? mem_wen[rd_ptr]   : 1'b0;
  assign rd_waddr = head_valid ? mem_waddr[rd_ptr] : '0;
`ifdef TRACE_HILO_EN
  assign rd_hi    = head_valid ? mem_hi[rd_ptr]    : '0;
  assign rd_lo    = head_valid ? mem_lo[rd_ptr]    : '0;
`endif

  assign state    = cur_state;
  assign count    = cnt;
  assign overflow = ovf;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: DEPTH=64 and DEPTH=8 instances share stimulus and are
// checked against a queue-based trace model. Build with TRACE_HILO_EN to cover HI/LO.
module tb_commit_trace_buffer;

  logic        clock;
  logic        reset;
  logic        arm;
  logic [31:0] trig_pc;
  logic [6:0]  post_cnt;
  logic        commit_valid;
  logic [31:0] commit_pc, commit_inst, commit_wdata, commit_hi, commit_lo;
  logic        commit_wen;
  logic [4:0]  commit_waddr;
  logic        rd_ready;

  logic        rv64, rv8, rwen64, rwen8, ovf64, ovf8;
  logic [31:0] rpc64, rpc8, rinst64, rinst8, rwd64, rwd8;
  logic [31:0] rhi64, rlo64, rhi8, rlo8;
  logic [4:0]  rwa64, rwa8;
  logic [1:0]  st64, st8;
  logic [6:0]  cnt64;
  logic [3:0]  cnt8;

  int n_vec;
  int n_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  commit_trace_buffer #(.DATA_W(32), .DEPTH(64), .RA_W(5)) u64 (
    .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_wdata(commit_wdata), .commit_wen(commit_wen), .commit_waddr(commit_waddr),
`ifdef TRACE_HILO_EN
    .commit_hi(commit_hi), .commit_lo(commit_lo), .rd_hi(rhi64), .rd_lo(rlo64),
`endif
    .rd_valid(rv64), .rd_ready(rd_ready), .rd_pc(rpc64), .rd_inst(rinst64),
    .rd_wdata(rwd64), .rd_wen(rwen64), .rd_waddr(rwa64),
    .state(st64), .count(cnt64), .overflow(ovf64)
  );

  commit_trace_buffer #(.DATA_W(32), .DEPTH(8), .RA_W(5)) u8 (
    .clock(clock), .reset(reset), .arm(arm), .trig_pc(trig_pc), .post_cnt(post_cnt[3:0]),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_wdata(commit_wdata), .commit_wen(commit_wen), .commit_waddr(commit_waddr),
`ifdef TRACE_HILO_EN
    .commit_hi(commit_hi), .commit_lo(commit_lo), .rd_hi(rhi8), .rd_lo(rlo8),
`endif
    .rd_valid(rv8), .rd_ready(rd_ready), .rd_pc(rpc8), .rd_inst(rinst8),
    .rd_wdata(rwd8), .rd_wen(rwen8), .rd_waddr(rwa8),
    .state(st8), .count(cnt8), .overflow(ovf8)
  );

`ifndef TRACE_HILO_EN
  assign rhi64 = '0;
  assign rlo64 = '0;
  assign rhi8  = '0;
  assign rlo8  = '0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] hi;
    logic [31:0] lo;
  } rec_t;

  rec_t       o_rec   [2];
  logic [1:0] o_state [2];
  logic [6:0] o_count [2];
  logic       o_ovf   [2];
  logic       o_valid [2];

  assign o_rec[0]   = {rpc64, rinst64, rwd64, rwen64, rwa64, rhi64, rlo64};
  assign o_rec[1]   = {rpc8, rinst8, rwd8, rwen8, rwa8, rhi8, rlo8};
  assign o_state[0] = st64;
  assign o_state[1] = st8;
  assign o_count[0] = cnt64;
  assign o_count[1] = {3'b000, cnt8};
  assign o_ovf[0]   = ovf64;
  assign o_ovf[1]   = ovf8;
  assign o_valid[0] = rv64;
  assign o_valid[1] = rv8;

  // Reference model: the trace is a queue of records, oldest at the front.
  // mode: 0 idle, 1 armed, 2 post-trigger, 3 frozen/readout.
  int   m_mode [2];
  int   m_post [2];
  int   m_rem  [2];
  bit   m_ovf  [2];
  rec_t mq     [2][$];

  function automatic int depth_of(int i);
    return (i == 0) ? 64 : 8;
  endfunction

  function automatic rec_t make_rec();
    rec_t r;
    r.pc    = commit_pc;
    r.inst  = commit_inst;
    r.wdata = commit_wdata;
    r.wen   = commit_wen;
    r.waddr = commit_waddr;
`ifdef TRACE_HILO_EN
    r.hi    = commit_hi;
    r.lo    = commit_lo;
`else
    r.hi    = '0;
    r.lo    = '0;
`endif
    return r;
  endfunction

  function automatic logic exp_valid(int i);
    return (m_mode[i] == 3) && (mq[i].size() > 0);
  endfunction

  function automatic rec_t exp_rec(int i);
    if (exp_valid(i)) return mq[i][0];
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0;
      m_post[i] = 0;
      m_rem[i]  = 0;
      m_ovf[i]  = 0;
      mq[i].delete();
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int d;
      int p;
      d = depth_of(i);
      p = (i == 0) ? int'(post_cnt) : int'(post_cnt[3:0]);
      if (arm) begin
        mq[i].delete();
        m_ovf[i]  = 0;
        m_mode[i] = 1;
        m_post[i] = (p > d - 1) ? d - 1 : p;
      end else if ((m_mode[i] == 1 || m_mode[i] == 2) && commit_valid) begin
        mq[i].push_back(make_rec());
        if (mq[i].size() > d) begin
          void'(mq[i].pop_front());
          m_ovf[i] = 1;
        end
        if (m_mode[i] == 1) begin
          if (commit_pc == trig_pc) begin
            if (m_post[i] == 0) m_mode[i] = 3;
            else begin
              m_mode[i] = 2;
              m_rem[i]  = m_post[i];
            end
          end
        end else begin
          m_rem[i]--;
          if (m_rem[i] == 0) m_mode[i] = 3;
        end
      end else if (m_mode[i] == 3) begin
        if (mq[i].size() > 0 && rd_ready) void'(mq[i].pop_front());
        if (mq[i].size() == 0) m_mode[i] = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_fields();
    commit_inst  = $urandom;
    commit_wdata = $urandom;
    commit_wen   = 1'($urandom);
    commit_waddr = 5'($urandom);
    commit_hi    = $urandom;
    commit_lo    = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    arm = 1'b0; commit_valid = 1'b0; rd_ready = 1'b0;
    trig_pc = '0; post_cnt = '0; commit_pc = '0;
    rand_fields();
    @(posedge clock); #1;
    @(posedge clock); #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (o_state[i] !== 2'b00 || o_count[i] !== 7'd0 || o_ovf[i] !== 1'b0 ||
          o_valid[i] !== 1'b0 || o_rec[i] !== rec_t'(0)) begin
        n_err++;
        $display("FAIL reset dut%0d: got st=%0d cnt=%0d ovf=%0b vld=%0b rec=%h, want all zero",
                 i, o_state[i], o_count[i], o_ovf[i], o_valid[i], o_rec[i]);
      end
    end
    #2 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_window();
    for (int t = 0; t < 13; t++) begin
      arm          = (t == 0);
      post_cnt     = 7'd2;
      trig_pc      = 32'h0040_0008;
      commit_valid = (t >= 1 && t <= 6);
      commit_pc    = 32'h0040_0000 + 32'(4 * (t - 1));
      rand_fields();
      rd_ready     = (t >= 7);
      if (t >= 7 && t <= 11) begin
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (o_rec[i].pc !== 32'h0040_0000 + 32'(4 * (t - 7))) begin
            n_err++;
            $display("FAIL window_order dut%0d t=%0d: rd_pc=%h want %h", i, t, o_rec[i].pc,
                     32'h0040_0000 + 32'(4 * (t - 7)));
          end
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (o_state[i] !== 2'(m_mode[i]) || o_count[i] !== 7'(mq[i].size()) ||
            o_ovf[i] !== m_ovf[i] || o_valid[i] !== exp_valid(i) || o_rec[i] !== exp_rec(i)) begin
          n_err++;
          $display("FAIL window dut%0d t=%0d: got st=%0d cnt=%0d ovf=%0b vld=%0b rec=%h, want st=%0d cnt=%0d ovf=%0b vld=%0b rec=%h",
                   i, t, o_state[i], o_count[i], o_ovf[i], o_valid[i], o_rec[i],
                   m_mode[i], mq[i].size(), m_ovf[i], exp_valid(i), exp_rec(i));
        end
      end
      if (t == 5) begin
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (o_state[i] !== 2'b11 || o_count[i] !== 7'd5 || o_ovf[i] !== 1'b0) begin
            n_err++;
            $display("FAIL window_done dut%0d: st=%0d cnt=%0d ovf=%0b want st=3 cnt=5 ovf=0",
                     i, o_state[i], o_count[i], o_ovf[i]);
          end
        end
      end
      if (t == 11) begin
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (o_state[i] !== 2'b00) begin
            n_err++;
            $display("FAIL window_idle dut%0d: st=%0d want 0", i, o_state[i]);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    for (int t = 0; t < 28; t++) begin
      arm          = (t == 0);
      post_cnt     = 7'd0;
      trig_pc      = 32'h0000_012C;
      commit_valid = (t >= 1 && t <= 12);
      commit_pc    = 32'h0000_0100 + 32'(4 * (t - 1));
      rand_fields();
      rd_ready     = (t >= 16);
      if (t >= 13 && t <= 16) begin
        n_vec++;
        if (o_valid[1] !== 1'b1 || o_rec[1].pc !== 32'h0000_0110) begin
          n_err++;
          $display("FAIL overflow_stall t=%0d: vld=%0b rd_pc=%h want vld=1 rd_pc=00000110",
                   t, o_valid[1], o_rec[1].pc);
        end
      end
      if (t == 23) begin
        n_vec++;
        if (o_rec[1].pc !== 32'h0000_012C) begin
          n_err++;
          $display("FAIL overflow_last: rd_pc=%h want 0000012c", o_rec[1].pc);
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (o_state[i] !== 2'(m_mode[i]) || o_count[i] !== 7'(mq[i].size()) ||
            o_ovf[i] !== m_ovf[i] || o_valid[i] !== exp_valid(i) || o_rec[i] !== exp_rec(i)) begin
          n_err++;
          $display("FAIL overflow dut%0d t=%0d: got st=%0d cnt=%0d ovf=%0b vld=%0b rec=%h, want st=%0d cnt=%0d ovf=%0b vld=%0b rec=%h",
                   i, t, o_state[i], o_count[i], o_ovf[i], o_valid[i], o_rec[i],
                   m_mode[i], mq[i].size(), m_ovf[i], exp_valid(i), exp_rec(i));
        end
      end
      if (t == 12) begin
        n_vec++;
        if (o_count[1] !== 7'd8 || o_ovf[1] !== 1'b1 || o_count[0] !== 7'd12 || o_ovf[0] !== 1'b0) begin
          n_err++;
          $display("FAIL overflow_flags: d8 cnt=%0d ovf=%0b d64 cnt=%0d ovf=%0b want 8/1 12/0",
                   o_count[1], o_ovf[1], o_count[0], o_ovf[0]);
        end
      end
    end
  endtask

  task automatic test_fields();
    for (int t = 0; t < 3; t++) begin
      arm          = (t == 0);
      post_cnt     = 7'd0;
      trig_pc      = 32'h0040_0040;
      commit_valid = (t == 1);
      commit_pc    = 32'h0040_0040;
      commit_inst  = 32'h3C09_DEAD;
      commit_wdata = 32'hDEAD_BEEF;
      commit_wen   = 1'b1;
      commit_waddr = 5'd9;
      commit_hi    = 32'h1;
      commit_lo    = 32'h2;
      rd_ready     = (t == 2);
      if (t == 2) begin
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (o_valid[i] !== 1'b1 || o_rec[i].wen !== 1'b1 || o_rec[i].waddr !== 5'd9 ||
              o_rec[i].wdata !== 32'hDEAD_BEEF || o_rec[i].inst !== 32'h3C09_DEAD) begin
            n_err++;
            $display("FAIL fields dut%0d: vld=%0b wen=%0b waddr=%0d wdata=%h inst=%h want 1 1 9 deadbeef 3c09dead",
                     i, o_valid[i], o_rec[i].wen, o_rec[i].waddr, o_rec[i].wdata, o_rec[i].inst);
          end
`ifdef TRACE_HILO_EN
          n_vec++;
          if (o_rec[i].hi !== 32'h1 || o_rec[i].lo !== 32'h2) begin
            n_err++;
            $display("FAIL hilo dut%0d: hi=%h lo=%h want 1 2", i, o_rec[i].hi, o_rec[i].lo);
          end
`endif
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (o_state[i] !== 2'(m_mode[i]) || o_count[i] !== 7'(mq[i].size()) ||
            o_ovf[i] !== m_ovf[i] || o_valid[i] !== exp_valid(i) || o_rec[i] !== exp_rec(i)) begin
          n_err++;
          $display("FAIL fields_model dut%0d t=%0d: got st=%0d cnt=%0d vld=%0b rec=%h, want st=%0d cnt=%0d vld=%0b rec=%h",
                   i, t, o_state[i], o_count[i], o_valid[i], o_rec[i],
                   m_mode[i], mq[i].size(), exp_valid(i), exp_rec(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid_post();
    for (int t = 0; t < 10; t++) begin
      if (t == 4) begin
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (o_state[i] !== 2'b00 || o_count[i] !== 7'd0 || o_valid[i] !== 1'b0 || o_rec[i] !== rec_t'(0)) begin
            n_err++;
            $display("FAIL async_reset dut%0d: st=%0d cnt=%0d vld=%0b rec=%h want zeros",
                     i, o_state[i], o_count[i], o_valid[i], o_rec[i]);
          end
        end
        model_reset();
      end
      if (t == 6) reset = 1'b1;
      arm          = (t == 0);
      post_cnt     = 7'd5;
      trig_pc      = 32'h0000_0200;
      commit_valid = (t >= 1);
      commit_pc    = (t == 2 || t == 3) ? 32'h0000_0200 + 32'(4 * (t - 1)) : 32'h0000_0200;
      rand_fields();
      rd_ready     = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (o_state[i] !== 2'(m_mode[i]) || o_count[i] !== 7'(mq[i].size()) ||
            o_ovf[i] !== m_ovf[i] || o_valid[i] !== exp_valid(i) || o_rec[i] !== exp_rec(i)) begin
          n_err++;
          $display("FAIL reset_post dut%0d t=%0d: got st=%0d cnt=%0d ovf=%0b vld=%0b, want st=%0d cnt=%0d ovf=%0b vld=%0b",
                   i, t, o_state[i], o_count[i], o_ovf[i], o_valid[i],
                   m_mode[i], mq[i].size(), m_ovf[i], exp_valid(i));
        end
        if (t == 3) begin
          n_vec++;
          if (o_state[i] !== 2'b10 || o_count[i] !== 7'd3) begin
            n_err++;
            $display("FAIL pre_reset dut%0d: st=%0d cnt=%0d want 2 3", i, o_state[i], o_count[i]);
          end
        end
        if (t >= 4) begin
          n_vec++;
          if (o_state[i] !== 2'b00 || o_count[i] !== 7'd0) begin
            n_err++;
            $display("FAIL no_resume dut%0d t=%0d: st=%0d cnt=%0d want 0 0", i, t, o_state[i], o_count[i]);
          end
        end
      end
    end
  endtask

  task automatic test_arm_same_cycle();
    for (int t = 0; t < 9; t++) begin
      arm          = (t == 0 || t == 7);
      post_cnt     = 7'd2;
      trig_pc      = 32'h0000_0308;
      commit_valid = (t <= 4);
      commit_pc    = 32'h0000_0300 + 32'(4 * t);
      rand_fields();
      rd_ready     = (t == 5 || t == 6);
      if (t == 5) begin
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (o_count[i] !== 7'd4 || o_rec[i].pc !== 32'h0000_0304) begin
            n_err++;
            $display("FAIL arm_drop dut%0d: cnt=%0d head=%h want 4 00000304", i, o_count[i], o_rec[i].pc);
          end
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (o_state[i] !== 2'(m_mode[i]) || o_count[i] !== 7'(mq[i].size()) ||
            o_ovf[i] !== m_ovf[i] || o_valid[i] !== exp_valid(i) || o_rec[i] !== exp_rec(i)) begin
          n_err++;
          $display("FAIL arm_model dut%0d t=%0d: got st=%0d cnt=%0d vld=%0b rec=%h, want st=%0d cnt=%0d vld=%0b rec=%h",
                   i, t, o_state[i], o_count[i], o_valid[i], o_rec[i],
                   m_mode[i], mq[i].size(), exp_valid(i), exp_rec(i));
        end
        if (t == 0 || t == 7) begin
          n_vec++;
          if (o_state[i] !== 2'b01 || o_count[i] !== 7'd0 || o_valid[i] !== 1'b0) begin
            n_err++;
            $display("FAIL rearm dut%0d t=%0d: st=%0d cnt=%0d vld=%0b want 1 0 0",
                     i, t, o_state[i], o_count[i], o_valid[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      logic [31:0] tp;
      tp = 32'h0040_0000 + 32'(4 * $urandom_range(0, 15));
      for (int c = 0; c < 250; c++) begin
        arm          = (c == 0) || ($urandom_range(0, 99) == 0);
        post_cnt     = 7'($urandom_range(0, 127));
        trig_pc      = tp;
        commit_valid = ($urandom_range(0, 3) != 0);
        commit_pc    = 32'h0040_0000 + 32'(4 * $urandom_range(0, 15));
        rand_fields();
        rd_ready     = 1'($urandom);
        tick();
        for (int i = 0; i < 2; i++) begin
          n_vec++;
          if (o_state[i] !== 2'(m_mode[i]) || o_count[i] !== 7'(mq[i].size()) ||
              o_ovf[i] !== m_ovf[i] || o_valid[i] !== exp_valid(i) || o_rec[i] !== exp_rec(i)) begin
            n_err++;
            $display("FAIL random dut%0d r=%0d c=%0d: got st=%0d cnt=%0d ovf=%0b vld=%0b rec=%h, want st=%0d cnt=%0d ovf=%0b vld=%0b rec=%h",
                     i, r, c, o_state[i], o_count[i], o_ovf[i], o_valid[i], o_rec[i],
                     m_mode[i], mq[i].size(), m_ovf[i], exp_valid(i), exp_rec(i));
          end
        end
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    test_reset();
    test_window();
    test_overflow();
    test_fields();
    test_reset_mid_post();
    test_arm_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
